vga_timing_gen: RTL and testbench

- Generates the 640x480 @ 60 Hz VGA raster from CLOCK_50, with a 25 MHz pixel enable.
- Exposes the current pixel coordinate to the upstream pixel generator and registers the RGB it returns.
- Drives the board VGA_* pins directly from registers, with syncs, blanking and colour aligned.
- Sits between the pixel/colour logic and the top-level VGA outputs of Project1.

---
 rtl/vga_timing_gen.sv | 129 ++++++++++++
 tb/tb_vga_timing_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster generator: 25 MHz pixel enable derived from CLOCK_50,
// coordinate counters for the pixel source, and registered sync/blank/colour pins.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned COLOR_W  = 8
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic [COLOR_W-1:0] pix_r,
  input  logic [COLOR_W-1:0] pix_g,
  input  logic [COLOR_W-1:0] pix_b,
  output logic [9:0]         pixel_x,
  output logic [9:0]         pixel_y,
  output logic               pixel_active,
  output logic               line_start,
  output logic               frame_start,
  output logic               VGA_CLK,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_LO = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_HI = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_LO = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_HI = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);

  logic               pix_en_q, pix_en_d;
  logic [9:0]         h_count_q, h_count_d;
  logic [9:0]         v_count_q, v_count_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               blank_n_q, blank_n_d;
  logic [COLOR_W-1:0] r_q, r_d;
  logic [COLOR_W-1:0] g_q, g_d;
  logic [COLOR_W-1:0] b_q, b_d;
  logic               active;

  always_comb begin
    active = (h_count_q < H_ACT_END) && (v_count_q < V_ACT_END);
  end

  // Counters and the output stage share the same pix_en edge, so every pin
  // reflects the coordinate that was on pixel_x/pixel_y one pixel earlier.
  always_comb begin
    pix_en_d  = ~pix_en_q;
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    if (pix_en_q) begin
      if (h_count_q == H_LAST) begin
        h_count_d = '0;
        v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + 10'd1;
      end else begin
        h_count_d = h_count_q + 10'd1;
      end
      hs_d      = !((h_count_q >= H_SYNC_LO) && (h_count_q < H_SYNC_HI));
      vs_d      = !((v_count_q >= V_SYNC_LO) && (v_count_q < V_SYNC_HI));
      blank_n_d = active;
      r_d       = active ? pix_r : '0;
      g_d       = active ? pix_g : '0;
      b_d       = active ? pix_b : '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      pix_en_q  <= 1'b0;
      h_count_q <= '0;
      v_count_q <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      pix_en_q  <= pix_en_d;
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end

  assign pixel_x      = h_count_q;
  assign pixel_y      = v_count_q;
  assign pixel_active = active;
  assign line_start   = pix_en_q && (h_count_q == '0);
  assign frame_start  = line_start && (v_count_q == '0);
  // DAC clock rises on the idle cycle, mid-way through each stable pixel.
  assign VGA_CLK      = pix_en_q;
  assign VGA_HS       = hs_q;
  assign VGA_VS       = vs_q;
  assign VGA_BLANK_N  = blank_n_q;
  assign VGA_SYNC_N   = 1'b0;
  assign VGA_R        = r_q;
  assign VGA_G        = g_q;
  assign VGA_B        = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full horizontal geometry, shortened vertical
// geometry (11 lines/frame) so several frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int unsigned VA = 4;
  localparam int unsigned VF = 2;
  localparam int unsigned VS = 2;
  localparam int unsigned VB = 3;
  localparam int VT = 11;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       loop_mode;
  logic [7:0] r_drv, g_drv, b_drv;
  logic [7:0] pix_r, pix_g, pix_b;
  logic [9:0] pixel_x, pixel_y;
  logic       pixel_active, line_start, frame_start;
  logic       vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
  logic [7:0] vga_r, vga_g, vga_b;

  int n_total = 0;
  int n_pass  = 0;
  int cyc;

  always #10 clk = ~clk;

  assign pix_r = loop_mode ? pixel_x[7:0] : r_drv;
  assign pix_g = g_drv;
  assign pix_b = b_drv;

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .COLOR_W(8)
  ) dut (
    .CLOCK_50(clk), .reset_n(reset_n),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_active(pixel_active),
    .line_start(line_start), .frame_start(frame_start),
    .VGA_CLK(vga_clk), .VGA_HS(vga_hs), .VGA_VS(vga_vs),
    .VGA_BLANK_N(vga_blank_n), .VGA_SYNC_N(vga_sync_n),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b)
  );

  // cyc = rising edges since reset release; pixel n is presented after edges 2n, 2n+1
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Running reference from the cycle count alone, sampled on falling edges
  int err_coord = 0, err_strobe = 0, err_sync = 0, err_rgb = 0, mon_cycles = 0;
  int mn, mp, mh, ml, eh, el;
  logic e_hs, e_vs, e_bl, e_ls, e_fs;
  logic [7:0] e_r, e_g, e_b;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      mon_cycles++;
      mn = cyc / 2;
      eh = mn % 800;
      el = (mn / 800) % VT;
      e_ls = (cyc % 2 == 1) && (eh == 0);
      e_fs = e_ls && (el == 0);
      if (pixel_x !== 10'(eh) || pixel_y !== 10'(el) ||
          pixel_active !== ((eh < 640) && (el < VA)))
        err_coord++;
      if (line_start !== e_ls || frame_start !== e_fs || vga_clk !== 1'(cyc % 2) ||
          vga_sync_n !== 1'b0)
        err_strobe++;
      if (cyc < 2) begin
        e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0;
        e_r = 8'h00; e_g = 8'h00; e_b = 8'h00;
      end else begin
        mp = (cyc - 2) / 2;
        mh = mp % 800;
        ml = (mp / 800) % VT;
        e_hs = !((mh >= 656) && (mh < 752));
        e_vs = !((ml >= 6) && (ml < 8));
        e_bl = (mh < 640) && (ml < VA);
        e_r  = e_bl ? (loop_mode ? 8'(mh) : 8'hFF) : 8'h00;
        e_g  = e_bl ? 8'h3C : 8'h00;
        e_b  = e_bl ? 8'hA5 : 8'h00;
      end
      if (vga_hs !== e_hs || vga_vs !== e_vs || vga_blank_n !== e_bl) err_sync++;
      if (vga_r !== e_r || vga_g !== e_g || vga_b !== e_b) err_rgb++;
    end
  end

  typedef struct {
    int         c;
    logic [7:0] r_in, g_in, b_in;
    logic [9:0] px, py;
    logic       ls, fs, vclk, hs, vs, bl;
    logic [7:0] r, g, b;
  } vec_t;

  function automatic vec_t mk(int c, int px, int py, logic ls, logic fs, logic vclk,
                              logic hs, logic vs, logic bl);
    vec_t v;
    v.c = c; v.r_in = 8'hFF; v.g_in = 8'h3C; v.b_in = 8'hA5;
    v.px = 10'(px); v.py = 10'(py);
    v.ls = ls; v.fs = fs; v.vclk = vclk; v.hs = hs; v.vs = vs; v.bl = bl;
    v.r = bl ? 8'hFF : 8'h00; v.g = bl ? 8'h3C : 8'h00; v.b = bl ? 8'hA5 : 8'h00;
    return v;
  endfunction

  vec_t tbl[19];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    //            c      px   py ls fs ck hs vs bl
    tbl[0]  = mk(1,     0,   0, 1, 1, 1, 1, 1, 0);
    tbl[1]  = mk(2,     1,   0, 0, 0, 0, 1, 1, 1);
    tbl[2]  = mk(3,     1,   0, 0, 0, 1, 1, 1, 1);
    tbl[3]  = mk(1280,  640, 0, 0, 0, 0, 1, 1, 1);
    tbl[4]  = mk(1282,  641, 0, 0, 0, 0, 1, 1, 0);
    tbl[5]  = mk(1313,  656, 0, 0, 0, 1, 1, 1, 0);
    tbl[6]  = mk(1314,  657, 0, 0, 0, 0, 0, 1, 0);
    tbl[7]  = mk(1504,  752, 0, 0, 0, 0, 0, 1, 0);
    tbl[8]  = mk(1506,  753, 0, 0, 0, 0, 1, 1, 0);
    tbl[9]  = mk(1601,  0,   1, 1, 0, 1, 1, 1, 0);
    tbl[10] = mk(1602,  1,   1, 0, 0, 0, 1, 1, 1);
    tbl[11] = mk(5002,  101, 3, 0, 0, 0, 1, 1, 1);
    tbl[12] = mk(6602,  101, 4, 0, 0, 0, 1, 1, 0);
    tbl[13] = mk(9601,  0,   6, 1, 0, 1, 1, 1, 0);
    tbl[14] = mk(9602,  1,   6, 0, 0, 0, 1, 0, 0);
    tbl[15] = mk(12801, 0,   8, 1, 0, 1, 1, 0, 0);
    tbl[16] = mk(12802, 1,   8, 0, 0, 0, 1, 1, 0);
    tbl[17] = mk(17601, 0,   0, 1, 1, 1, 1, 1, 0);
    tbl[18] = mk(17602, 1,   0, 0, 0, 0, 1, 1, 1);

    reset_n = 1'b0; loop_mode = 1'b0;
    r_drv = 8'hFF; g_drv = 8'h3C; b_drv = 8'hA5;
    #600;
    check("reset_pins", {vga_hs, vga_vs, vga_blank_n, vga_clk, vga_sync_n, vga_r, vga_g, vga_b},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0});
    check("reset_coord", {pixel_x, pixel_y, line_start, frame_start}, {10'd0, 10'd0, 2'b00});
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      r_drv = tbl[i].r_in; g_drv = tbl[i].g_in; b_drv = tbl[i].b_in;
      goto(tbl[i].c);
      check($sformatf("vec%0d_coord", i),
            {pixel_x, pixel_y, line_start, frame_start, vga_clk},
            {tbl[i].px, tbl[i].py, tbl[i].ls, tbl[i].fs, tbl[i].vclk});
      check($sformatf("vec%0d_pins", i),
            {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b},
            {tbl[i].hs, tbl[i].vs, tbl[i].bl, tbl[i].r, tbl[i].g, tbl[i].b});
    end

    // switch the red source to pixel_x while the raster is in vertical blanking
    goto(25620);
    loop_mode = 1'b1;
    goto(35201);
    check("pipe_pre", {pixel_x, pixel_y, vga_blank_n, vga_r}, {10'd0, 10'd0, 1'b0, 8'h00});
    goto(35202);
    check("pipe_first", {pixel_x, vga_blank_n, vga_r}, {10'd1, 1'b1, 8'h00});
    goto(35204);
    check("pipe_second", {pixel_x, vga_r}, {10'd2, 8'h01});
    goto(35712);
    check("pipe_255", {pixel_x, vga_r}, {10'd256, 8'hFF});
    goto(35714);
    check("pipe_wrap", {pixel_x, vga_r}, {10'd257, 8'h00});

    goto(39000);
    check("mid_before", {pixel_x, pixel_y, vga_blank_n, vga_r}, {10'd300, 10'd2, 1'b1, 8'h2B});
    #3 reset_n = 1'b0;
    #1;
    check("mid_reset_pins", {vga_hs, vga_vs, vga_blank_n, vga_clk, vga_r, vga_g, vga_b},
          {1'b1, 1'b1, 1'b0, 1'b0, 24'h0});
    check("mid_reset_coord", {pixel_x, pixel_y}, {10'd0, 10'd0});
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    goto(1);
    check("restart_frame", {pixel_x, pixel_y, frame_start}, {10'd0, 10'd0, 1'b1});
    goto(9601);
    check("restart_vs_pre", {pixel_y, vga_vs}, {10'd6, 1'b1});
    goto(9602);
    check("restart_vs_low", {pixel_y, vga_vs}, {10'd6, 1'b0});
    @(negedge clk);

    check("mon_coord_errs", 64'(err_coord), 64'd0);
    check("mon_strobe_errs", 64'(err_strobe), 64'd0);
    check("mon_sync_errs", 64'(err_sync), 64'd0);
    check("mon_rgb_errs", 64'(err_rgb), 64'd0);
    check("mon_ran", 64'(mon_cycles > 45000), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
